// File: rtl/nios2_oci_dct_sequencer.sv
// nios2_oci_dct_sequencer
//
// Packs 2-bit data-trace codes into a 15-slot (30-bit) DCT buffer and hands
// full or partial buffers to the trace FIFO as frames. It also sequences the
// end-of-test drain: any partial buffer is flushed, then test_has_ended is
// raised and held.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   code_valid     trace code offered by the dtrace logic
//   code           trace code value
//   code_ready     sequencer can accept a code this cycle
//   flush          single-cycle request to emit the partial buffer
//   test_ending    end-of-test request, sampled every cycle
//   frame_valid    frame offered to the trace FIFO
//   frame_data     packed frame, slot n at bits [2n+1:2n]
//   frame_count    number of valid slots in frame_data (1..15)
//   frame_ready    trace FIFO accepts the frame
//   dct_buffer     live accumulation buffer
//   dct_count      live code count (0..14)
//   test_has_ended drain complete, sticky until reset
module nios2_oci_dct_sequencer #(
   parameter  int CODE_W = 2,
   parameter  int SLOTS  = 15,
   localparam int BUF_W  = CODE_W * SLOTS,
   localparam int CNT_W  = $clog2(SLOTS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              code_valid,
   input  logic [CODE_W-1:0] code,
   output logic              code_ready,
   input  logic              flush,
   input  logic              test_ending,
   output logic              frame_valid,
   output logic [BUF_W-1:0]  frame_data,
   output logic [CNT_W-1:0]  frame_count,
   input  logic              frame_ready,
   output logic [BUF_W-1:0]  dct_buffer,
   output logic [CNT_W-1:0]  dct_count,
   output logic              test_has_ended
);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_EMIT  = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [BUF_W-1:0]   dct_buffer_reg, dct_buffer_next;
   logic [CNT_W-1:0]   dct_count_reg, dct_count_next;
   logic [BUF_W-1:0]   frame_data_reg, frame_data_next;
   logic [CNT_W-1:0]   frame_count_reg, frame_count_next;
   logic               frame_valid_reg, frame_valid_next;
   logic               ending_pend_reg, ending_pend_next;
   logic               test_has_ended_reg, test_has_ended_next;

   logic               accept;
   logic               ending_req;
   logic [CNT_W-1:0]   eff_count;
   logic [BUF_W-1:0]   buf_acc;

   // Readiness depends only on the state register (never on frame_ready);
   // the reset term keeps it low while reset is held.
   assign code_ready = (state_reg == ST_ACCUM) && !reset;
   assign accept     = code_valid && code_ready;
   assign eff_count  = dct_count_reg + CNT_W'(accept);
   assign ending_req = test_ending || ending_pend_reg;

   // Buffer as it looks after this cycle's accepted code lands in slot
   // dct_count; the emit decision and the emitted frame both use it.
   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign buf_acc[gi*CODE_W +: CODE_W] =
         (accept && (dct_count_reg == CNT_W'(gi))) ? code
                                                   : dct_buffer_reg[gi*CODE_W +: CODE_W];
   end

   always_comb begin
      state_next          = state_reg;
      dct_buffer_next     = dct_buffer_reg;
      dct_count_next      = dct_count_reg;
      frame_data_next     = frame_data_reg;
      frame_count_next    = frame_count_reg;
      frame_valid_next    = frame_valid_reg;
      test_has_ended_next = test_has_ended_reg;
      ending_pend_next    = ending_pend_reg || (test_ending && (state_reg != ST_DONE));

      case (state_reg)
         ST_ACCUM: begin
            dct_buffer_next = buf_acc;
            dct_count_next  = eff_count;
            if ((eff_count == CNT_W'(SLOTS)) ||
                ((flush || ending_req) && (eff_count != '0))) begin
               frame_data_next  = buf_acc;
               frame_count_next = eff_count;
               frame_valid_next = 1'b1;
               dct_buffer_next  = '0;
               dct_count_next   = '0;
               state_next       = ST_EMIT;
            end else if (ending_req) begin
               // Nothing left to drain: finish straight away.
               test_has_ended_next = 1'b1;
               state_next          = ST_DONE;
            end
         end
         ST_EMIT: begin
            // Frame is held stable until the FIFO takes it; flush is dropped.
            if (frame_ready) begin
               frame_valid_next = 1'b0;
               if (ending_req) begin
                  test_has_ended_next = 1'b1;
                  state_next          = ST_DONE;
               end else begin
                  state_next = ST_ACCUM;
               end
            end
         end
         ST_DONE: begin
            // Terminal until reset.
         end
         default: begin
            state_next = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg          <= ST_ACCUM;
         dct_buffer_reg     <= '0;
         dct_count_reg      <= '0;
         frame_data_reg     <= '0;
         frame_count_reg    <= '0;
         frame_valid_reg    <= 1'b0;
         ending_pend_reg    <= 1'b0;
         test_has_ended_reg <= 1'b0;
      end else begin
         state_reg          <= state_next;
         dct_buffer_reg     <= dct_buffer_next;
         dct_count_reg      <= dct_count_next;
         frame_data_reg     <= frame_data_next;
         frame_count_reg    <= frame_count_next;
         frame_valid_reg    <= frame_valid_next;
         ending_pend_reg    <= ending_pend_next;
         test_has_ended_reg <= test_has_ended_next;
      end
   end

   assign frame_valid    = frame_valid_reg;
   assign frame_data     = frame_data_reg;
   assign frame_count    = frame_count_reg;
   assign dct_buffer     = dct_buffer_reg;
   assign dct_count      = dct_count_reg;
   assign test_has_ended = test_has_ended_reg;

endmodule

// File: tb/tb_nios2_oci_dct_sequencer.sv
// Self-checking bench for nios2_oci_dct_sequencer: a table of frame
// scenarios applied in a loop, a scoreboard queue of expected frames checked
// at each FIFO handshake, plus hand-written sequences for the corner cases.
module tb_nios2_oci_dct_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        code_valid = 1'b0;
   logic [1:0]  code = 2'd0;
   logic        code_ready;
   logic        flush = 1'b0;
   logic        test_ending = 1'b0;
   logic        frame_valid;
   logic [29:0] frame_data;
   logic [3:0]  frame_count;
   logic        frame_ready = 1'b0;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_has_ended;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nios2_oci_dct_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .code_valid     (code_valid),
      .code           (code),
      .code_ready     (code_ready),
      .flush          (flush),
      .test_ending    (test_ending),
      .frame_valid    (frame_valid),
      .frame_data     (frame_data),
      .frame_count    (frame_count),
      .frame_ready    (frame_ready),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_has_ended (test_has_ended)
   );

   // trig: 0 = last code completes the buffer, 1 = flush cycle after codes,
   //       2 = flush together with the last code, 3 = test_ending cycle after codes
   typedef struct {
      int          n;
      logic [29:0] codes;
      int          trig;
      int          stall;
      bit          end_in_emit;
      logic [29:0] exp_data;
      logic [3:0]  exp_count;
      bit          exp_done;
   } vec_t;

   typedef struct {
      logic [29:0] data;
      logic [3:0]  count;
   } frame_t;

   vec_t   vecs[6];
   frame_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every handshake must match the oldest expected frame.
   always @(negedge clk) begin
      if (!reset && frame_valid && frame_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_frame", {2'b0, frame_data}, 32'h0);
            check("unexpected_frame_count", {28'b0, frame_count}, 32'h0);
         end else begin
            frame_t f;
            f = sb.pop_front();
            $display("frame handshake: count=%0d data=0x%08h (expect count=%0d data=0x%08h)",
                     frame_count, frame_data, f.count, f.data);
            check("frame_data", {2'b0, frame_data}, {2'b0, f.data});
            check("frame_count", {28'b0, frame_count}, {28'b0, f.count});
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      code_valid = 1'b0; flush = 1'b0; test_ending = 1'b0; frame_ready = 1'b0;
      tick();
      tick();
      check("rst_code_ready", {31'b0, code_ready}, 32'd0);
      check("rst_frame_valid", {31'b0, frame_valid}, 32'd0);
      check("rst_frame_data", {2'b0, frame_data}, 32'd0);
      check("rst_frame_count", {28'b0, frame_count}, 32'd0);
      check("rst_dct_buffer", {2'b0, dct_buffer}, 32'd0);
      check("rst_dct_count", {28'b0, dct_count}, 32'd0);
      check("rst_has_ended", {31'b0, test_has_ended}, 32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_code_ready", {31'b0, code_ready}, 32'd1);
   endtask

   task automatic apply_vec(input vec_t v, input bit rst_first);
      frame_t f;
      if (rst_first) do_reset();
      f.data = v.exp_data;
      f.count = v.exp_count;
      sb.push_back(f);
      frame_ready = (v.stall == 0);
      for (int i = 0; i < v.n; i++) begin
         code_valid = 1'b1;
         code = v.codes[2*i +: 2];
         flush = (v.trig == 2) && (i == v.n - 1);
         @(negedge clk);
         check("accept_code_ready", {31'b0, code_ready}, 32'd1);
         tick();
      end
      code_valid = 1'b0;
      flush = 1'b0;
      if (v.trig == 1 || v.trig == 3) begin
         check("accum_dct_count", {28'b0, dct_count}, {28'b0, v.exp_count});
         check("accum_dct_buffer", {2'b0, dct_buffer}, {2'b0, v.exp_data});
         flush = (v.trig == 1);
         test_ending = (v.trig == 3);
         tick();
         flush = 1'b0;
         test_ending = 1'b0;
      end
      // One cycle after the triggering edge the frame must be on offer.
      check("emit_frame_valid", {31'b0, frame_valid}, 32'd1);
      check("emit_code_ready", {31'b0, code_ready}, 32'd0);
      check("emit_dct_count", {28'b0, dct_count}, 32'd0);
      for (int s = 0; s < v.stall; s++) begin
         test_ending = v.end_in_emit && (s == 0);
         flush = (s == 1);
         check("stall_frame_valid", {31'b0, frame_valid}, 32'd1);
         check("stall_frame_data", {2'b0, frame_data}, {2'b0, v.exp_data});
         check("stall_frame_count", {28'b0, frame_count}, {28'b0, v.exp_count});
         check("stall_code_ready", {31'b0, code_ready}, 32'd0);
         tick();
      end
      test_ending = 1'b0;
      flush = 1'b0;
      frame_ready = 1'b1;
      tick();
      check("post_hs_frame_valid", {31'b0, frame_valid}, 32'd0);
      check("post_hs_has_ended", {31'b0, test_has_ended}, {31'b0, v.exp_done});
      check("post_hs_code_ready", {31'b0, code_ready}, {31'b0, !v.exp_done});
      check("sb_drained", sb.size(), 32'd0);
      if (v.exp_done) begin
         for (int k = 0; k < 3; k++) begin
            code_valid = 1'b1;
            code = 2'd3;
            flush = 1'b1;
            tick();
            check("done_code_ready", {31'b0, code_ready}, 32'd0);
            check("done_dct_count", {28'b0, dct_count}, 32'd0);
            check("done_sticky", {31'b0, test_has_ended}, 32'd1);
            check("done_frame_valid", {31'b0, frame_valid}, 32'd0);
         end
         code_valid = 1'b0;
         flush = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{n: 15, codes: 30'h39E79E79, trig: 0, stall: 0, end_in_emit: 0,
                  exp_data: 30'h39E79E79, exp_count: 4'd15, exp_done: 0};
      vecs[1] = '{n: 3, codes: 30'h23, trig: 1, stall: 5, end_in_emit: 0,
                  exp_data: 30'h23, exp_count: 4'd3, exp_done: 0};
      vecs[2] = '{n: 5, codes: 30'h325, trig: 3, stall: 0, end_in_emit: 0,
                  exp_data: 30'h325, exp_count: 4'd5, exp_done: 1};
      vecs[3] = '{n: 1, codes: 30'h2, trig: 2, stall: 1, end_in_emit: 0,
                  exp_data: 30'h2, exp_count: 4'd1, exp_done: 0};
      vecs[4] = '{n: 15, codes: 30'h3FFFFFFF, trig: 0, stall: 3, end_in_emit: 1,
                  exp_data: 30'h3FFFFFFF, exp_count: 4'd15, exp_done: 1};
      vecs[5] = '{n: 7, codes: 30'h0, trig: 1, stall: 2, end_in_emit: 0,
                  exp_data: 30'h0, exp_count: 4'd7, exp_done: 0};

      for (int i = 0; i < 6; i++) begin
         $display("vector %0d: %0d codes, trig=%0d", i, vecs[i].n, vecs[i].trig);
         apply_vec(vecs[i], 1'b1);
      end

      // Flush on an empty buffer produces nothing.
      do_reset();
      frame_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("empty_flush_valid", {31'b0, frame_valid}, 32'd0);
      check("empty_flush_ready", {31'b0, code_ready}, 32'd1);
      tick();
      check("empty_flush_valid2", {31'b0, frame_valid}, 32'd0);
      $display("empty flush: no frame");

      // test_ending with an empty buffer finishes one cycle later.
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      check("empty_end_has_ended", {31'b0, test_has_ended}, 32'd1);
      check("empty_end_code_ready", {31'b0, code_ready}, 32'd0);
      check("empty_end_valid", {31'b0, frame_valid}, 32'd0);
      tick();
      check("empty_end_sticky", {31'b0, test_has_ended}, 32'd1);
      $display("empty test_ending: drained");

      // Asynchronous reset while a full frame is stalled in EMIT.
      begin
         vec_t v;
         frame_t f;
         do_reset();
         v = vecs[4];
         f.data = v.exp_data;
         f.count = v.exp_count;
         sb.push_back(f);
         frame_ready = 1'b0;
         test_ending = 1'b0;
         for (int i = 0; i < 15; i++) begin
            code_valid = 1'b1;
            code = 2'd3;
            tick();
         end
         code_valid = 1'b0;
         check("pre_async_valid", {31'b0, frame_valid}, 32'd1);
         #2;
         reset = 1'b1;
         #1;
         check("async_frame_valid", {31'b0, frame_valid}, 32'd0);
         check("async_dct_count", {28'b0, dct_count}, 32'd0);
         check("async_has_ended", {31'b0, test_has_ended}, 32'd0);
         check("async_code_ready", {31'b0, code_ready}, 32'd0);
         sb.delete();
         $display("async reset mid-emit: frame discarded");
         tick();
         reset = 1'b0;
         #1;
         apply_vec(vecs[0], 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
